// File: rtl/simon_pkg.sv
// Shared types for the Simon round sequencer.
// State encodings, symbol type and sizing helpers.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHOW_ON  = 3'd1,
    ST_SHOW_OFF = 3'd2,
    ST_WAIT_BTN = 3'd3,
    ST_CHECK    = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  typedef logic [1:0] sym_t;

  localparam sym_t BTN_NONE = 2'b11;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/simon_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV clocks.
// i_clr restarts the count so a new phase starts aligned.
module simon_tick_gen
  import simon_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // prescaler: wrap at LAST, restart on clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/simon_round_sequencer.sv
// Simon round controller: playback, button window, win/lose.
// Optional SIMON_RETRY_EN grants one replay per game on failure.
module simon_round_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEN       = 15,
  parameter int CLK_DIV       = 4,
  parameter int ON_TICKS      = 2,
  parameter int OFF_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] seq_sym,
  output logic [3:0] seq_idx,
  output logic       show_valid,
  input  logic       btn_valid,
  input  logic [1:0] btn_id,
  output logic       btn_ready,
  output logic [3:0] level,
  output logic [2:0] state_o,
  output logic       win,
  output logic       lose
);

  localparam int PH_MAXV =
    max3(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS);
  localparam int PW = cnt_w(PH_MAXV);

  localparam logic [PW-1:0] ON_LAST  = PW'(ON_TICKS - 1);
  localparam logic [PW-1:0] OFF_LAST = PW'(OFF_TICKS - 1);
  localparam logic [PW-1:0] TO_LAST  = PW'(TIMEOUT_TICKS - 1);
  localparam logic [PW-1:0] PH_SAT   = PW'(PH_MAXV - 1);
  localparam logic [3:0]    LVL_LAST = 4'(MAX_LEN - 1);

  state_e        r_state;
  logic [3:0]    r_idx;
  logic [3:0]    r_level;
  sym_t          r_cap;
  logic [PW-1:0] r_phase;
  logic          r_show;
  logic          r_ready;
  logic          r_win;
  logic          r_lose;

  state_e        w_nxt_state;
  logic [3:0]    w_nxt_idx;
  logic [3:0]    w_nxt_level;
  sym_t          w_nxt_cap;
  logic          w_fail;
  logic          w_clr;
  logic          w_tick;

`ifdef SIMON_RETRY_EN
  logic          r_retry;
  logic          w_nxt_retry;
`endif

  assign w_clr = (w_nxt_state != r_state);

  simon_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  // next-state, index, level and capture decisions
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_level = r_level;
    w_nxt_cap   = r_cap;
    w_fail      = 1'b0;
`ifdef SIMON_RETRY_EN
    w_nxt_retry = r_retry;
`endif
    unique case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          w_nxt_state = ST_SHOW_ON;
          w_nxt_idx   = '0;
          w_nxt_level = '0;
`ifdef SIMON_RETRY_EN
          w_nxt_retry = 1'b0;
`endif
        end
      end
      ST_SHOW_ON: begin
        if (w_tick && (r_phase == ON_LAST)) begin
          w_nxt_state = ST_SHOW_OFF;
        end
      end
      ST_SHOW_OFF: begin
        if (w_tick && (r_phase == OFF_LAST)) begin
          if (r_idx == r_level) begin
            w_nxt_idx   = '0;
            w_nxt_state = ST_WAIT_BTN;
          end else begin
            w_nxt_idx   = r_idx + 4'd1;
            w_nxt_state = ST_SHOW_ON;
          end
        end
      end
      ST_WAIT_BTN: begin
        if (btn_valid) begin
          w_nxt_cap   = btn_id;
          w_nxt_state = ST_CHECK;
        end else if (w_tick && (r_phase == TO_LAST)) begin
          w_fail = 1'b1;
        end
      end
      ST_CHECK: begin
        if ((r_cap == BTN_NONE) || (r_cap != seq_sym)) begin
          w_fail = 1'b1;
        end else if (r_idx < r_level) begin
          w_nxt_idx   = r_idx + 4'd1;
          w_nxt_state = ST_WAIT_BTN;
        end else if (r_level == LVL_LAST) begin
          w_nxt_state = ST_WIN;
        end else begin
          w_nxt_level = r_level + 4'd1;
          w_nxt_idx   = '0;
          w_nxt_state = ST_SHOW_ON;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    if (w_fail) begin
`ifdef SIMON_RETRY_EN
      if (!r_retry) begin
        w_nxt_retry = 1'b1;
        w_nxt_idx   = '0;
        w_nxt_state = ST_SHOW_ON;
      end else begin
        w_nxt_state = ST_LOSE;
      end
`else
      w_nxt_state = ST_LOSE;
`endif
    end
  end

  // state, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_level <= '0;
      r_cap   <= '0;
      r_show  <= 1'b0;
      r_ready <= 1'b0;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_level <= w_nxt_level;
      r_cap   <= w_nxt_cap;
      r_show  <= (w_nxt_state == ST_SHOW_ON);
      r_ready <= (w_nxt_state == ST_WAIT_BTN);
      r_win   <= (w_nxt_state == ST_WIN);
      r_lose  <= (w_nxt_state == ST_LOSE);
    end
  end

  // tick counter within a phase, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
    end else if (w_clr) begin
      r_phase <= '0;
    end else if (w_tick && (r_phase != PH_SAT)) begin
      r_phase <= r_phase + PW'(1);
    end
  end

`ifdef SIMON_RETRY_EN
  // one replay allowed per game
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retry <= 1'b0;
    end else begin
      r_retry <= w_nxt_retry;
    end
  end
`endif

  assign seq_idx    = r_idx;
  assign level      = r_level;
  assign state_o    = r_state;
  assign show_valid = r_show;
  assign btn_ready  = r_ready;
  assign win        = r_win;
  assign lose       = r_lose;

endmodule

// File: tb/tb_simon_round_sequencer.sv
// Randomized bench for simon_round_sequencer.
// Game-level model of playback timing, presses and outcomes.
module tb_simon_round_sequencer;

  localparam int MAX_LEN = 3;
  localparam int CDIV    = 4;
  localparam int ON_T    = 2;
  localparam int OFF_T   = 1;
  localparam int TO_T    = 8;
  localparam int ON_CYC  = ON_T * CDIV;
  localparam int SYM_CYC = (ON_T + OFF_T) * CDIV;
  localparam int TO_CYC  = TO_T * CDIV;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] seq_sym;
  logic [3:0] seq_idx;
  logic       show_valid;
  logic       btn_valid;
  logic [1:0] btn_id;
  logic       btn_ready;
  logic [3:0] level;
  logic [2:0] state_o;
  logic       win;
  logic       lose;

  logic [1:0] store [16];
  int n_cmp;
  int n_bad;
  bit m_retry;

  assign seq_sym = store[seq_idx];

  simon_round_sequencer #(
    .MAX_LEN      (MAX_LEN),
    .CLK_DIV      (CDIV),
    .ON_TICKS     (ON_T),
    .OFF_TICKS    (OFF_T),
    .TIMEOUT_TICKS(TO_T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seq_sym   (seq_sym),
    .seq_idx   (seq_idx),
    .show_valid(show_valid),
    .btn_valid (btn_valid),
    .btn_id    (btn_id),
    .btn_ready (btn_ready),
    .level     (level),
    .state_o   (state_o),
    .win       (win),
    .lose      (lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] obs_now();
    return {state_o, show_valid, btn_ready,
            seq_idx, level, win, lose};
  endfunction

  function automatic logic [14:0] mk(
    input int st, input bit sh, input bit rd,
    input int idx, input int lvl,
    input bit w, input bit l
  );
    return {3'(st), sh, rd, 4'(idx), 4'(lvl), w, l};
  endfunction

  function automatic string fmt(input logic [14:0] o);
    return $sformatf(
      "st=%0d sv=%0b rdy=%0b idx=%0d lvl=%0d w=%0b l=%0b",
      o[14:12], o[11], o[10], o[9:6], o[5:2], o[1], o[0]);
  endfunction

  function automatic int pick_d();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return TO_CYC - 1;
    if (r == 1) return 0;
    return int'($urandom_range(0, TO_CYC - 1));
  endfunction

  task automatic cyc();
    @(negedge clk);
    start     = 1'b0;
    btn_valid = 1'b0;
  endtask

  task automatic model_fail(output bit is_lose);
`ifdef SIMON_RETRY_EN
    if (!m_retry) begin
      m_retry = 1'b1;
      is_lose = 1'b0;
    end else begin
      is_lose = 1'b1;
    end
`else
    is_lose = 1'b1;
`endif
  endtask

  task automatic expect_playback(input int L);
    logic [14:0] e;
    for (int k = 0; k <= L; k++) begin
      for (int c = 0; c < SYM_CYC; c++) begin
        cyc();
        if (c < ON_CYC) e = mk(1, 1, 0, k, L, 0, 0);
        else            e = mk(2, 0, 0, k, L, 0, 0);
        n_cmp++;
        if (obs_now() !== e) begin
          n_bad++;
          $display("FAIL playback L%0d k%0d c%0d: got %s want %s",
                   L, k, c, fmt(obs_now()), fmt(e));
        end
        if ($urandom_range(0, 5) == 0) start = 1'b1;
        if ($urandom_range(0, 5) == 0) begin
          btn_valid = 1'b1;
          btn_id    = 2'($urandom_range(0, 3));
        end
      end
    end
  endtask

  task automatic wait_press(
    input int L, input int k, input int d, input logic [1:0] id
  );
    logic [14:0] e;
    for (int i = 0; i <= d; i++) begin
      cyc();
      e = mk(3, 0, 1, k, L, 0, 0);
      n_cmp++;
      if (obs_now() !== e) begin
        n_bad++;
        $display("FAIL wait L%0d k%0d i%0d: got %s want %s",
                 L, k, i, fmt(obs_now()), fmt(e));
      end
      if ($urandom_range(0, 7) == 0) start = 1'b1;
    end
    btn_valid = 1'b1;
    btn_id    = id;
    cyc();
    e = mk(4, 0, 0, k, L, 0, 0);
    n_cmp++;
    if (obs_now() !== e) begin
      n_bad++;
      $display("FAIL check_state L%0d k%0d d%0d: got %s want %s",
               L, k, d, fmt(obs_now()), fmt(e));
    end
    if ($urandom_range(0, 1) == 0) start = 1'b1;
  endtask

  task automatic wait_timeout(input int L, input int k);
    logic [14:0] e;
    for (int i = 0; i < TO_CYC; i++) begin
      cyc();
      e = mk(3, 0, 1, k, L, 0, 0);
      n_cmp++;
      if (obs_now() !== e) begin
        n_bad++;
        $display("FAIL timeout_wait L%0d k%0d i%0d: got %s want %s",
                 L, k, i, fmt(obs_now()), fmt(e));
      end
    end
  endtask

  task automatic expect_end(
    input int st, input int L, input int k,
    output logic [14:0] fin
  );
    cyc();
    fin = mk(st, 0, 0, k, L, st == 5, st == 6);
    n_cmp++;
    if (obs_now() !== fin) begin
      n_bad++;
      $display("FAIL end_state L%0d k%0d: got %s want %s",
               L, k, fmt(obs_now()), fmt(fin));
    end
  endtask

  // kind: 0 wrong symbol, 1 no-button code, 2 timeout
  task automatic play_game(
    input int fail_lvl, input int fail_k,
    input int kind, input int fails_in,
    output logic [14:0] fin
  );
    int L;
    int fl;
    bit done;
    bit replay;
    bit is_lose;
    int s;
    logic [1:0] id;
    fl = fails_in;
    m_retry = 1'b0;
    fin = '0;
    cyc();
    start = 1'b1;
    L = 0;
    done = 1'b0;
    while (!done) begin
      expect_playback(L);
      replay = 1'b0;
      for (int k = 0; k <= L; k++) begin
        if (replay || done) break;
        if (L == fail_lvl && k == fail_k && fl > 0) begin
          fl--;
          if (kind == 2) begin
            wait_timeout(L, k);
          end else begin
            s = int'(store[k]);
            if (kind == 1) id = 2'b11;
            else id = 2'((s + 1 + int'($urandom_range(0, 1))) % 3);
            wait_press(L, k, pick_d(), id);
          end
          model_fail(is_lose);
          if (is_lose) begin
            expect_end(6, L, k, fin);
            done = 1'b1;
          end else begin
            replay = 1'b1;
          end
        end else begin
          wait_press(L, k, pick_d(), store[k]);
        end
      end
      if (!replay && !done) begin
        if (L == MAX_LEN - 1) begin
          expect_end(5, L, L, fin);
          done = 1'b1;
        end else begin
          L++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs_now() !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_value: got %s want all zero",
               fmt(obs_now()));
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc();
    n_cmp++;
    if (obs_now() !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %s want all zero",
               fmt(obs_now()));
    end
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_cmp++;
      if (obs_now() !== 15'd0) begin
        n_bad++;
        $display("FAIL idle_btn i%0d: got %s want all zero",
                 i, fmt(obs_now()));
      end
      btn_valid = 1'b1;
      btn_id    = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic test_fixed_win();
    logic [14:0] fin;
    for (int i = 0; i < 16; i++) store[i] = 2'd0;
    store[0] = 2'b00;
    store[1] = 2'b01;
    store[2] = 2'b10;
    play_game(-1, 0, 0, 0, fin);
  endtask

  task automatic test_lose_hold();
    logic [14:0] fin;
    play_game(1, 0, 0, 2, fin);
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_cmp++;
      if (obs_now() !== fin) begin
        n_bad++;
        $display("FAIL lose_hold i%0d: got %s want %s",
                 i, fmt(obs_now()), fmt(fin));
      end
      btn_valid = 1'b1;
      btn_id    = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic test_timeout();
    logic [14:0] fin;
    play_game(0, 0, 2, 2, fin);
    play_game(2, 1, 2, 2, fin);
  endtask

  task automatic test_btn_none();
    logic [14:0] fin;
    play_game(2, 2, 1, 2, fin);
  endtask

  task automatic test_async_reset();
    cyc();
    start = 1'b1;
    repeat (5) cyc();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs_now() !== 15'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %s want all zero",
               fmt(obs_now()));
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs_now() !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_held: got %s want all zero",
               fmt(obs_now()));
    end
    @(negedge clk);
    rst = 1'b1;
    cyc();
    n_cmp++;
    if (obs_now() !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_release: got %s want all zero",
               fmt(obs_now()));
    end
  endtask

  task automatic test_random_games();
    logic [14:0] fin;
    int fl;
    int fk;
    for (int g = 0; g < 12; g++) begin
      for (int i = 0; i < 16; i++)
        store[i] = 2'($urandom_range(0, 2));
      fl = int'($urandom_range(0, MAX_LEN)) - 1;
      fk = (fl < 0) ? 0 : int'($urandom_range(0, fl));
      play_game(fl, fk, int'($urandom_range(0, 2)),
                int'($urandom_range(1, 2)), fin);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    m_retry   = 1'b0;
    rst       = 1'b0;
    start     = 1'b0;
    btn_valid = 1'b0;
    btn_id    = 2'b00;
    for (int i = 0; i < 16; i++) store[i] = 2'd0;
    test_reset();
    test_idle_ignore();
    test_fixed_win();
    test_fixed_win();
    test_lose_hold();
    test_timeout();
    test_btn_none();
    test_async_reset();
    test_random_games();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
